acs_metric_collect: RTL

ACS_METRIC_COLLECT -- requirements
Module: acs_metric_collect

---
 rtl/acs_metric_collect_pkg.sv | 18 +
 rtl/acs_metric_collect_metric_bank_ram.sv | 30 +++
 rtl/acs_metric_collect.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/acs_metric_collect_pkg.sv
// Purpose : shared widths, limits and types for the ACS metric collector.
// Contents: METRIC_W, NUM_STATES, STATE_W, BEATS_PER_STAGE, METRIC_MAX and
//           the metric/state/beat scalar types used by every file.
package acs_metric_collect_pkg;

    localparam int METRIC_W        = 18;
    localparam int NUM_STATES      = 32;
    localparam int STATE_W         = 5;
    localparam int BEATS_PER_STAGE = 16;
    localparam int BEAT_W          = 4;

    typedef logic [METRIC_W-1:0] metric_t;
    typedef logic [STATE_W-1:0]  state_t;
    typedef logic [BEAT_W-1:0]   beat_t;

    localparam metric_t METRIC_MAX = '1;

endpackage

// File: rtl/acs_metric_collect_metric_bank_ram.sv
// Purpose : one 32 x 18 metric bank; a beat writes its even/odd pair at once.
// Ports   : clk; we/wr_pair/wr_even/wr_odd write port (words 2k and 2k+1);
//           re/rd_addr/rd_dat synchronous read port, rd_dat valid next cycle.
module metric_bank_ram
    import acs_metric_collect_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  beat_t   wr_pair,
    input  metric_t wr_even,
    input  metric_t wr_odd,
    input  logic    re,
    input  state_t  rd_addr,
    output metric_t rd_dat
);

    // Contents are intentionally not reset.
    metric_t mem [NUM_STATES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_pair, 1'b0}] <= wr_even;
            mem[{wr_pair, 1'b1}] <= wr_odd;
        end
        if (re) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/acs_metric_collect.sv
// Purpose : collects one trellis stage of 32 state metrics (16 pair beats) into
//           a ping-pong bank pair, reports the stage minimum and its state,
//           and replays the oldest complete bank on request.
// Ports   : clk/reset (sync, active-high); startStage, metricInEn,
//           accMetricEvenIn/OddIn collection input; bestValid/bestMetric/
//           bestState stage result; readStart request and metricOutEn/
//           metricOut/metricOutState replay output; bankReady, overrun status.
// Config  : ACS_NORMALIZE_EN defined -> replayed metrics have the bank's
//           minimum subtracted; undefined -> raw stored metrics.
module acs_metric_collect
    import acs_metric_collect_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    startStage,
    input  logic    metricInEn,
    input  metric_t accMetricEvenIn,
    input  metric_t accMetricOddIn,
    input  logic    readStart,
    output logic    bestValid,
    output metric_t bestMetric,
    output state_t  bestState,
    output logic    metricOutEn,
    output metric_t metricOut,
    output state_t  metricOutState,
    output logic    bankReady,
    output logic    overrun
);

    logic    active;
    beat_t   beat_cnt;
    metric_t run_min;
    state_t  run_idx;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic    wr_bank;
    logic    rd_bank;
    logic    rd_busy;
    state_t  rd_addr;
    logic    out_bank;
    metric_t bank_dat [2];

    // A startStage in the same cycle as a beat restarts the stage and takes
    // that beat as beat 0, so the beat sees the fresh counter and minimum.
    beat_t   beat_k;
    metric_t min_base;
    state_t  idx_base;
    logic    take;
    logic    even_lt;
    logic    odd_lt;
    metric_t min_e;
    state_t  idx_e;
    metric_t min_o;
    state_t  idx_o;
    logic    last_beat;
    logic    rd_go;
    logic    rd_last;

    assign beat_k   = startStage ? '0 : beat_cnt;
    assign min_base = startStage ? METRIC_MAX : run_min;
    assign idx_base = startStage ? '0 : run_idx;
    assign take     = metricInEn && (active || startStage);

    // Strict compares: ties keep the earlier (lower) state, even before odd.
    assign even_lt  = accMetricEvenIn < min_base;
    assign min_e    = even_lt ? accMetricEvenIn : min_base;
    assign idx_e    = even_lt ? {beat_k, 1'b0} : idx_base;
    assign odd_lt   = accMetricOddIn < min_e;
    assign min_o    = odd_lt ? accMetricOddIn : min_e;
    assign idx_o    = odd_lt ? {beat_k, 1'b1} : idx_e;

    assign last_beat = take && (beat_k == beat_t'(BEATS_PER_STAGE - 1));
    assign bankReady = |full;
    assign rd_go     = readStart && bankReady && !rd_busy;
    assign rd_last   = rd_busy && (rd_addr == state_t'(NUM_STATES - 1));

    // Completion and replay-finish always target different banks in normal
    // operation; both updates are applied.
    always_comb begin
        full_nxt = full;
        if (rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (last_beat) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active         <= 1'b0;
            beat_cnt       <= '0;
            run_min        <= METRIC_MAX;
            run_idx        <= '0;
            full           <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            rd_busy        <= 1'b0;
            rd_addr        <= '0;
            out_bank       <= 1'b0;
            overrun        <= 1'b0;
            bestValid      <= 1'b0;
            bestMetric     <= '0;
            bestState      <= '0;
            metricOutEn    <= 1'b0;
            metricOutState <= '0;
        end else begin
            bestValid <= 1'b0;
            if (startStage) begin
                active   <= 1'b1;
                beat_cnt <= '0;
                run_min  <= METRIC_MAX;
                run_idx  <= '0;
            end
            if (take) begin
                beat_cnt <= beat_t'(beat_k + 1'b1);
                run_min  <= min_o;
                run_idx  <= idx_o;
                if ((beat_k == '0) && full[wr_bank]) begin
                    overrun <= 1'b1;
                end
                if (last_beat) begin
                    active     <= 1'b0;
                    bestValid  <= 1'b1;
                    bestMetric <= min_o;
                    bestState  <= idx_o;
                    wr_bank    <= ~wr_bank;
                end
            end
            full <= full_nxt;

            // Reader: address issued one cycle, RAM data and beat valid the next.
            metricOutEn    <= rd_busy;
            metricOutState <= rd_addr;
            out_bank       <= rd_bank;
            if (rd_go) begin
                rd_busy <= 1'b1;
                rd_addr <= '0;
            end else if (rd_busy) begin
                rd_addr <= state_t'(rd_addr + 1'b1);
            end
            if (rd_last) begin
                rd_busy <= 1'b0;
                rd_bank <= ~rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        metric_bank_ram u_ram (
            .clk     (clk),
            .we      (take && (wr_bank == 1'(b))),
            .wr_pair (beat_k),
            .wr_even (accMetricEvenIn),
            .wr_odd  (accMetricOddIn),
            .re      (rd_busy && (rd_bank == 1'(b))),
            .rd_addr (rd_addr),
            .rd_dat  (bank_dat[b])
        );
    end

`ifdef ACS_NORMALIZE_EN
    // Each bank keeps the minimum of the stage written into it.
    metric_t bank_min [2];
    metric_t out_min;

    always_ff @(posedge clk) begin
        if (last_beat) begin
            bank_min[wr_bank] <= min_o;
        end
        out_min <= bank_min[rd_bank];
    end

    assign metricOut = metricOutEn ? metric_t'(bank_dat[out_bank] - out_min) : '0;
`else
    assign metricOut = metricOutEn ? bank_dat[out_bank] : '0;
`endif

endmodule
